// File: rtl/gate_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Steps one logic gate under test through every input vector,
//               checks its output against a reference and reports the result.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
    parameter int N_IN = 2,
    parameter int HOLD = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            dut_y,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            op_err,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            op_err_q, op_err_d;
    logic [N_IN:0]   err_count_q, err_count_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;

    logic            w_expected;
    logic            w_mismatch;

    // Reference output of the latched gate function for the current vector
    always_comb begin
        w_expected = 1'b0;
        case (op_q)
            3'd0:    w_expected = &vec_q;
            3'd1:    w_expected = |vec_q;
            3'd2:    w_expected = ~&vec_q;
            3'd3:    w_expected = ~|vec_q;
            3'd4:    w_expected = ^vec_q;
            3'd5:    w_expected = ~^vec_q;
            default: w_expected = 1'b0;
        endcase
    end

    assign w_mismatch = (dut_y != w_expected);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        vec_d        = vec_q;
        hold_d       = hold_q;
        pass_d       = pass_q;
        op_err_d     = op_err_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d         = op;
                    vec_d        = '0;
                    hold_d       = '0;
                    pass_d       = 1'b0;
                    op_err_d     = 1'b0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    if (op < 3'd6) begin
                        state_d = S_SWEEP;
                    end else begin
                        state_d  = S_DONE;
                        op_err_d = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                if (hold_q == c_HOLD_LAST) begin
                    hold_d = '0;
                    if (w_mismatch) begin
                        if (!(&err_count_q)) begin
                            err_count_d = err_count_q + (N_IN + 1)'(1);
                        end
                        if (!fail_valid_q) begin
                            fail_vec_d   = vec_q;
                            fail_valid_d = 1'b1;
                        end
                    end
                    if (&vec_q) begin
                        state_d = S_DONE;
                        // Final sample counts toward the verdict
                        pass_d  = !(fail_valid_q || w_mismatch);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_SWEEP);
        done_d   = (state_d == S_DONE);
        dut_in_d = busy_d ? vec_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            vec_q        <= '0;
            hold_q       <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            op_err_q     <= 1'b0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            vec_q        <= vec_d;
            hold_q       <= hold_d;
            dut_in_q     <= dut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            op_err_q     <= op_err_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign op_err     = op_err_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Directed bench for gate_sweep_ctrl with behavioural gate models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start_a, start_b;
    logic [2:0] op_a, op_b;
    logic [1:0] mode_a;
    logic       dut_y_a, dut_y_b;
    logic [1:0] dut_in_a;
    logic [2:0] dut_in_b;
    logic       busy_a, done_a, pass_a, op_err_a, fail_valid_a;
    logic       busy_b, done_b, pass_b, op_err_b, fail_valid_b;
    logic [2:0] err_count_a;
    logic [3:0] err_count_b;
    logic [1:0] fail_vec_a;
    logic [2:0] fail_vec_b;

    int checks   = 0;
    int failures = 0;

    gate_sweep_ctrl #(.N_IN(2), .HOLD(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .dut_y(dut_y_a),
        .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .op_err(op_err_a), .err_count(err_count_a), .fail_valid(fail_valid_a),
        .fail_vec(fail_vec_a)
    );

    gate_sweep_ctrl #(.N_IN(3), .HOLD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .dut_y(dut_y_b),
        .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .op_err(op_err_b), .err_count(err_count_b), .fail_valid(fail_valid_b),
        .fail_vec(fail_vec_b)
    );

    // Gate models: 0 = NOR, 1 = stuck at 0, 2 = AND
    always_comb begin
        dut_y_a = 1'b0;
        case (mode_a)
            2'd0:    dut_y_a = ~|dut_in_a;
            2'd1:    dut_y_a = 1'b0;
            2'd2:    dut_y_a = &dut_in_a;
            default: dut_y_a = 1'b0;
        endcase
    end
    assign dut_y_b = &dut_in_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a sweep on DUT A and leaves time at edge k+20 (done expected)
    task automatic sweep_a(input logic [2:0] o, input logic [1:0] m);
        mode_a  = m;
        op_a    = o;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("a_busy_at_start", busy_a, 1);
        check("a_err_cleared", err_count_a, 0);
        check("a_fail_valid_cleared", fail_valid_a, 0);
        repeat (19) step();
        check("a_done_not_early", done_a, 0);
        step();
        check("a_done_pulse", done_a, 1);
        check("a_busy_end", busy_a, 0);
        check("a_dut_in_end", dut_in_a, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        op_a    = 3'd0;
        op_b    = 3'd0;
        mode_a  = 2'd0;
        repeat (2) step();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_count_a, 0);
        check("rst_dut_in", dut_in_a, 0);
        check("rst_b_busy", busy_b, 0);
        rst_n = 1'b1;
        step();

        // Clean NOR sweep with per-cycle vector checks
        mode_a  = 2'd0;
        op_a    = 3'd3;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int j = 0; j < 20; j++) begin
            check("nor_dut_in", dut_in_a, j / 5);
            check("nor_busy", busy_a, 1);
            check("nor_done_low", done_a, 0);
            step();
        end
        check("nor_done", done_a, 1);
        check("nor_busy_end", busy_a, 0);
        check("nor_dut_in_end", dut_in_a, 0);
        check("nor_pass", pass_a, 1);
        check("nor_err", err_count_a, 0);
        check("nor_fail_valid", fail_valid_a, 0);
        // start coincident with done must be dropped
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("start_in_done_ignored", busy_a, 0);
        check("nor_done_one_cycle", done_a, 0);
        check("nor_pass_held", pass_a, 1);
        step();

        // NOR expected, gate stuck at 0: only vector 00 disagrees
        sweep_a(3'd3, 2'd1);
        check("stuck_err", err_count_a, 1);
        check("stuck_fail_vec", fail_vec_a, 0);
        check("stuck_fail_valid", fail_valid_a, 1);
        check("stuck_pass", pass_a, 0);
        step();

        // XOR expected, NOR gate: disagree at 00, 01, 10
        sweep_a(3'd4, 2'd0);
        check("xor_err", err_count_a, 3);
        check("xor_fail_vec", fail_vec_a, 0);
        check("xor_pass", pass_a, 0);
        step();

        // OR expected, AND gate: disagree at 01, 10
        sweep_a(3'd1, 2'd2);
        check("or_err", err_count_a, 2);
        check("or_fail_vec", fail_vec_a, 1);
        check("or_fail_valid", fail_valid_a, 1);
        check("or_pass", pass_a, 0);
        step();

        // Invalid op
        op_a    = 3'd6;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("inv_done", done_a, 1);
        check("inv_op_err", op_err_a, 1);
        check("inv_pass", pass_a, 0);
        check("inv_busy", busy_a, 0);
        check("inv_dut_in", dut_in_a, 0);
        check("inv_err", err_count_a, 0);
        step();
        check("inv_done_low", done_a, 0);
        check("inv_op_err_held", op_err_a, 1);
        check("inv_busy_after", busy_a, 0);

        // AND sweep with an ignored start and op change at cycle 7
        mode_a  = 2'd2;
        op_a    = 3'd0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("and_op_err_cleared", op_err_a, 0);
        repeat (6) step();
        start_a = 1'b1;
        op_a    = 3'd3;
        step();
        start_a = 1'b0;
        check("and_busy_mid", busy_a, 1);
        repeat (12) step();
        check("and_done_not_early", done_a, 0);
        step();
        check("and_done", done_a, 1);
        check("and_pass_op_latched", pass_a, 1);
        check("and_err", err_count_a, 0);
        step();

        // Reset mid-sweep at cycle 12
        op_a    = 3'd0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (12) step();
        check("pre_rst_dut_in", dut_in_a, 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy_a, 0);
        check("async_rst_dut_in", dut_in_a, 0);
        check("async_rst_done", done_a, 0);
        check("async_rst_pass", pass_a, 0);
        repeat (10) step();
        check("rst_no_done", done_a, 0);
        check("rst_hold_busy", busy_a, 0);
        rst_n = 1'b1;
        step();
        sweep_a(3'd0, 2'd2);
        check("post_rst_pass", pass_a, 1);
        check("post_rst_err", err_count_a, 0);
        step();

        // Wider gate, single-cycle hold
        op_b    = 3'd0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("b_dut_in", dut_in_b, j);
            check("b_done_low", done_b, 0);
            step();
        end
        check("b_done", done_b, 1);
        check("b_busy_end", busy_b, 0);
        check("b_pass", pass_b, 1);
        check("b_err", err_count_b, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
